// File: rtl/line_writeback_reader.sv
// line_writeback_reader
// Read-side engine for the cache data RAM. A request names a RAM row and
// a line-aligned writeback address. The engine issues one read, captures
// the whole row on the following cycle, then streams it out as BEATS
// narrower beats, lowest beat first, using a valid/ready handshake.
//
// Ports
//   clk, reset          single clock; asynchronous active-low reset
//   req_valid/ready     request handshake; ready is combinational (IDLE only)
//   req_index/req_addr  row to read / writeback address carried through
//   enb/addrb           RAM read port; data returns on rdata one cycle later
//   rdata               full RAM row
//   wb_valid/ready      beat handshake; wb_data/wb_last/wb_addr are the payload
//   busy/busy_index     line currently read or drained, used by refill logic
//                       to hold off writes to that row
module line_writeback_reader #(
    parameter int ramDepth  = 128,
    parameter int portWidth = 256,
    parameter int beatWidth = 32,
    parameter int addrWidth = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(ramDepth)-1:0] req_index,
    input  logic [addrWidth-1:0]        req_addr,
    output logic                        enb,
    output logic [$clog2(ramDepth)-1:0] addrb,
    input  logic [portWidth-1:0]        rdata,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [beatWidth-1:0]        wb_data,
    output logic                        wb_last,
    output logic [addrWidth-1:0]        wb_addr,
    output logic                        busy,
    output logic [$clog2(ramDepth)-1:0] busy_index
);

    localparam int IDX_W = $clog2(ramDepth);
    localparam int BEATS = portWidth / beatWidth;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [portWidth-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_last_q, wb_last_d;
    logic [addrWidth-1:0]   wb_addr_q, wb_addr_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       busy_index_q, busy_index_d;

    logic                   req_ready_s;
    logic                   enb_s;
    logic                   beat_hs_s;

    // Request acceptance and RAM read strobe; ready is gated by reset so
    // nothing is accepted (and no read issued) while reset is held.
    always_comb begin
        req_ready_s = (state_q == ST_IDLE) && reset;
        enb_s       = req_valid && req_ready_s;
        beat_hs_s   = wb_valid_q && wb_ready;
    end

    // Next-state and datapath updates for the IDLE/CAPTURE/SEND sequence.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        wb_valid_d   = wb_valid_q;
        wb_last_d    = wb_last_q;
        wb_addr_d    = wb_addr_q;
        busy_d       = busy_q;
        busy_index_d = busy_index_q;
        case (state_q)
            ST_IDLE: begin
                if (enb_s) begin
                    busy_index_d = req_index;
                    wb_addr_d    = req_addr;
                    busy_d       = 1'b1;
                    state_d      = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // rdata belongs to the read issued last cycle; this is the
                // only point at which row content enters the engine.
                shreg_d    = rdata;
                cnt_d      = {CNT_W{1'b0}};
                wb_valid_d = 1'b1;
                wb_last_d  = (LAST_CNT == {CNT_W{1'b0}});
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (beat_hs_s) begin
                    shreg_d = shreg_q >> beatWidth;
                    if (cnt_q == LAST_CNT) begin
                        // Counter stays at its final value; it is cleared
                        // again on the next capture.
                        wb_valid_d = 1'b0;
                        wb_last_d  = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        wb_last_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
                    end
                end else begin
                    // Backpressure: payload and last flag hold.
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wb_valid_d = 1'b0;
                wb_last_d  = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= {portWidth{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_last_q    <= 1'b0;
            wb_addr_q    <= {addrWidth{1'b0}};
            busy_q       <= 1'b0;
            busy_index_q <= {IDX_W{1'b0}};
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            wb_valid_q   <= wb_valid_d;
            wb_last_q    <= wb_last_d;
            wb_addr_q    <= wb_addr_d;
            busy_q       <= busy_d;
            busy_index_q <= busy_index_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign enb        = enb_s;
    assign addrb      = req_index;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = shreg_q[beatWidth-1:0];
    assign wb_last    = wb_last_q;
    assign wb_addr    = wb_addr_q;
    assign busy       = busy_q;
    assign busy_index = busy_index_q;

endmodule

// File: tb/tb_line_writeback_reader.sv
// Directed + randomized bench for line_writeback_reader. A RAM model with a
// one-cycle read (output follows the last read address) feeds the DUT;
// expected beats are sliced straight out of the row as it stood when read.
module tb_line_writeback_reader;

    localparam int DEPTH = 128;
    localparam int PW    = 256;
    localparam int BW    = 32;
    localparam int AW    = 32;
    localparam int BEATS = PW / BW;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [6:0]      req_index;
    logic [AW-1:0]   req_addr;
    logic            enb;
    logic [6:0]      addrb;
    logic [PW-1:0]   rdata;
    logic            wb_valid;
    logic            wb_ready;
    logic [BW-1:0]   wb_data;
    logic            wb_last;
    logic [AW-1:0]   wb_addr;
    logic            busy;
    logic [6:0]      busy_index;

    logic [PW-1:0]   mem [DEPTH];
    logic [6:0]      rd_addr;
    int              n_cmp = 0;
    int              n_err = 0;

    line_writeback_reader #(
        .ramDepth(DEPTH), .portWidth(PW), .beatWidth(BW), .addrWidth(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_addr(req_addr),
        .enb(enb), .addrb(addrb), .rdata(rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_last(wb_last), .wb_addr(wb_addr),
        .busy(busy), .busy_index(busy_index)
    );

    always #5 clk = ~clk;

    // RAM model: output register tracks the most recently enabled address.
    always @(posedge clk) begin
        if (enb) begin
            rd_addr <= addrb;
            rdata   <= mem[addrb];
        end else begin
            rdata   <= mem[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full burst. in_cycle0: request already presented and accepted in
    // the current cycle (chained from the previous burst).
    task automatic burst(input int idx, input logic [AW-1:0] addr,
                         input int stall_beat, input int stall_len,
                         input bit rand_stall, input bit modify_ram,
                         input bit chain, input int nidx, input logic [AW-1:0] naddr,
                         input bit in_cycle0);
        logic [PW-1:0] row;
        logic [BW-1:0] w;
        int ns;
        row = mem[idx];
        if (!in_cycle0) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_index = 7'(idx); req_addr = addr; wb_ready = 1'b1;
            @(negedge clk);
        end
        chk("c0_req_ready", 64'(req_ready), 64'(1));
        chk("c0_enb", 64'(enb), 64'(1));
        chk("c0_addrb", 64'(addrb), 64'(idx));
        @(posedge clk); #1;
        if (chain) begin
            req_valid = 1'b1; req_index = 7'(nidx); req_addr = naddr;
        end else begin
            req_valid = 1'b0;
        end
        @(negedge clk);
        chk("c1_busy", 64'(busy), 64'(1));
        chk("c1_busy_index", 64'(busy_index), 64'(idx));
        chk("c1_wb_valid", 64'(wb_valid), 64'(0));
        chk("c1_enb", 64'(enb), 64'(0));
        for (int k = 0; k < BEATS; k++) begin
            if (k == stall_beat) ns = stall_len;
            else if (rand_stall) ns = int'($urandom_range(0, 2));
            else ns = 0;
            w = row[k*BW +: BW];
            for (int s = 0; s <= ns; s++) begin
                @(posedge clk); #1;
                if (modify_ram && k == 0 && s == 0) mem[idx] = ~row;
                wb_ready = (s == ns);
                @(negedge clk);
                chk("beat_valid", 64'(wb_valid), 64'(1));
                chk("beat_data", 64'(wb_data), 64'(w));
                chk("beat_last", 64'(wb_last), 64'(k == BEATS - 1));
                chk("beat_addr", 64'(wb_addr), 64'(addr));
                chk("beat_busy", 64'(busy), 64'(1));
                chk("beat_busy_index", 64'(busy_index), 64'(idx));
                chk("beat_req_ready", 64'(req_ready), 64'(0));
                chk("beat_enb", 64'(enb), 64'(0));
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("end_wb_valid", 64'(wb_valid), 64'(0));
        chk("end_wb_last", 64'(wb_last), 64'(0));
        chk("end_busy", 64'(busy), 64'(0));
        chk("end_req_ready", 64'(req_ready), 64'(1));
        chk("end_wb_addr", 64'(wb_addr), 64'(addr));
        chk("end_enb", 64'(enb), 64'(chain));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_enb"}, 64'(enb), 64'(0));
        chk({tag, "_wb_valid"}, 64'(wb_valid), 64'(0));
        chk({tag, "_wb_last"}, 64'(wb_last), 64'(0));
        chk({tag, "_wb_data"}, 64'(wb_data), 64'(0));
        chk({tag, "_wb_addr"}, 64'(wb_addr), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_busy_index"}, 64'(busy_index), 64'(0));
    endtask

    initial begin
        logic [PW-1:0] row9;
        int ridx;
        reset = 1'b0; req_valid = 1'b0; req_index = 7'd0; req_addr = 32'd0;
        wb_ready = 1'b1; rd_addr = 7'd0; rdata = '0;
        for (int r = 0; r < DEPTH; r++)
            for (int j = 0; j < BEATS; j++)
                mem[r][j*BW +: BW] = $urandom;
        for (int j = 0; j < BEATS; j++) mem[5][j*BW +: BW] = 32'(j);

        // Reset state, with a request pending that must not be accepted.
        repeat (2) @(posedge clk);
        #1 req_valid = 1'b1; req_index = 7'd3;
        @(negedge clk);
        chk_reset_vals("rst");
        req_valid = 1'b0;
        reset = 1'b1;

        // Single request, row 5 holds word i = i.
        burst(5, 32'h8000_1000, -1, 0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
        // Backpressure: three stall cycles at beat 3.
        burst(5, 32'h8000_1020, 3, 3, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
        // Back-to-back: index 1 then index 2 held valid throughout.
        burst(1, 32'h0000_0040, -1, 0, 1'b0, 1'b0, 1'b1, 2, 32'h0000_0080, 1'b0);
        burst(2, 32'h0000_0080, -1, 0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1);
        // Row 5 rewritten after capture; stream must carry the old content.
        burst(5, 32'h8000_1040, -1, 0, 1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0);
        chk("ram_modified", 64'(mem[5][31:0]), 64'(32'hFFFF_FFFF));

        // Reset pulse during beat 4.
        row9 = mem[9];
        @(posedge clk); #1;
        req_valid = 1'b1; req_index = 7'd9; req_addr = 32'hA000_0100; wb_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_beat4", 64'(wb_data), 64'(row9[4*BW +: BW]));
        chk("pre_rst_last", 64'(wb_last), 64'(0));
        #1 reset = 1'b0; req_valid = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("held_rst");
        req_valid = 1'b0;
        reset = 1'b1;
        burst(9, 32'hA000_0200, -1, 0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);

        // Randomized bursts with random backpressure.
        for (int t = 0; t < 6; t++) begin
            ridx = int'($urandom_range(0, DEPTH - 1));
            burst(ridx, {$urandom} & 32'hFFFF_FFE0, -1, 0, 1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_writeback_reader.md
# line_writeback_reader

Read-side engine for the cache data RAM. Accepts a line index and writeback address, issues a single one-cycle-latency read on the RAM read port, captures the full line, and streams it out as a burst of narrower beats with valid/ready handshake and a last flag. Sits between the cache data array and the AXI write-data path, and serves dirty-line eviction and uncached flush. A `busy`/`busy_index` pair lets refill logic hold off writes to the line being drained.

## Interface
- `ramDepth`, 128, number of RAM rows; one row holds one cache line.
- `portWidth`, 256, RAM row width in bits; equals the line size.
- `beatWidth`, 32, output beat width; `portWidth % beatWidth == 0` and `portWidth / beatWidth >= 2`.
- `addrWidth`, 32, width of the writeback address carried through.
- `clk`  in  1  single clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-low; assertion takes effect immediately, deassertion is synchronous to `clk`.
- `req_valid`  in  1  writeback request present.
- `req_ready`  out  1  engine can accept a request.
- `req_index`  in  $clog2(ramDepth)  RAM row to read.
- `req_addr`  in  addrWidth  line-aligned writeback address.
- `enb`  out  1  RAM read enable.
- `addrb`  out  $clog2(ramDepth)  RAM read address.
- `rdata`  in  portWidth  RAM read data, valid the cycle after `enb`.
- `wb_valid`  out  1  beat valid.
- `wb_ready`  in  1  downstream accepts beat.
- `wb_data`  out  beatWidth  beat payload.
- `wb_last`  out  1  final beat of the line.
- `wb_addr`  out  addrWidth  latched `req_addr`, stable for the whole burst.
- `busy`  out  1  a line is being read or drained.
- `busy_index`  out  $clog2(ramDepth)  index of the line in flight.

## Operation
- BEATS = portWidth/beatWidth. The beat counter is $clog2(BEATS) bits wide.
- The FSM has three states: IDLE, CAPTURE, SEND.
- `req_ready` = (state == IDLE) and reset deasserted. It is a combinational output.
- IDLE: on `req_valid && req_ready`:
  - `enb` = 1 and `addrb` = `req_index`, both combinational in the same cycle.
  - Latch `req_index` into `busy_index` and `req_addr` into `wb_addr`.
  - Set `busy` = 1 and go to CAPTURE.
  - Otherwise `enb` = 0 and `addrb` = `req_index`; the value of `addrb` is a don't-care while `enb` = 0.
- CAPTURE: register `rdata` into the line shift register. Clear the beat counter, set `wb_valid` = 1, and go to SEND. `enb` = 0.
- SEND: `wb_data` = the low `beatWidth` bits of the shift register. Beat 0 is `rdata[beatWidth-1:0]`, in ascending order.
  - On `wb_valid && wb_ready`: shift right by `beatWidth` and increment the counter.
  - `wb_last` = 1 exactly when the counter equals BEATS-1.
  - A handshake on the last beat sets `wb_valid` = 0, `wb_last` = 0 and `busy` = 0, and returns to IDLE.
- Backpressure: while `wb_valid && !wb_ready`, `wb_data`, `wb_last` and `wb_addr` hold unchanged. `wb_valid` never drops before the handshake.
- Hazard: the block does not detect writes to `busy_index` on the RAM write port. Writers must stall while `busy` is set and the index matches. Only the row content sampled in CAPTURE is sent.
- `wb_valid` does not depend combinationally on `wb_ready`.

## Timing
- Reset values: state IDLE, `wb_valid` 0, `wb_last` 0, `wb_data` 0, `wb_addr` 0, `busy` 0, `busy_index` 0, beat counter 0. While reset is asserted, `req_ready` = 0 and `enb` = 0.
- Cycle numbering below assumes the request is accepted in cycle 0:
  - Cycle 0: `enb` high.
  - Cycle 1: CAPTURE.
  - Cycle 2: first beat valid.
- With `wb_ready` held high, the last beat handshakes in cycle BEATS+1 and `req_ready` is 1 in cycle BEATS+2.
- Back-to-back request period is BEATS+2 cycles; this is 10 for the defaults.
- No request is accepted in the cycle of the final beat handshake.
- `busy` rises in cycle 1 and falls in the cycle after the last handshake.
- Reset asserted mid-burst: all state returns to reset values immediately and the partial burst is abandoned with no `wb_last`. After deassertion, the first request is handled normally.
- Widths: the counter wraps to 0 only through the IDLE→CAPTURE path. It never increments past BEATS-1.

## Test plan
- Single request, `wb_ready` always 1, `req_index` = 5, row 5 = 0x…_00000007_00000006_…_00000000 (word i = i):
  - `enb`/`addrb` = 5 in cycle 0.
  - Beats 0..7 appear in cycles 2..9 with data = 0..7.
  - `wb_last` only in cycle 9.
  - `busy` high in cycles 1..9.
  - `req_ready` = 1 in cycle 10.
- Backpressure: `wb_ready` = 0 for 3 cycles at beat 3 -> `wb_data` = 3 is held and `wb_valid` stays 1. The burst completes 3 cycles later and no beat is lost or duplicated.
- Back-to-back: two requests presented continuously (index 1, then 2) -> the second is accepted exactly 10 cycles after the first. `wb_addr` changes only after the first burst's last beat.
- RAM changes row 5 after CAPTURE -> the output stream still carries the value captured in cycle 1.
- Reset pulse during beat 4:
  - All outputs take their reset values asynchronously and there is no `wb_last`.
  - A new request after release streams a full 8 beats correctly.
- `req_valid` high while busy -> `req_ready` = 0 and `enb` stays 0 until the current burst ends.
